mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/arb_timeout_counter.sv | 35 +++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and default parameters for the memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_D = 1'b0,
        OWN_I = 1'b1
    } owner_t;

    localparam int STARVE_LIMIT_DEFAULT = 4;
    localparam int TIMEOUT_DEFAULT      = 255;

endpackage

`default_nettype wire

// File: rtl/arb_timeout_counter.sv
// ============================================================================
// Module      : arb_timeout_counter
// Description : Counts WAIT cycles; expired flags the last allowed WAIT cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_count;

    // r_count holds the number of WAIT cycles already completed
    assign expired = enable && (r_count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port (data/instruction) arbiter onto one memory port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int TIMEOUT      = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    input  logic        i_read,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    output logic        mem_oe,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t    r_state;
    arb_state_t    w_state_next;
    owner_t        r_owner;
    logic          r_write;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [SW-1:0] r_starve;

    logic w_d_req;
    logic w_any_req;
    logic w_grant_i;
    logic w_in_wait;
    logic w_expired;
    logic w_finish;

    assign w_d_req   = d_read | d_write;
    assign w_any_req = w_d_req | i_read;
    // Instruction wins when data is idle or data has used up its starvation budget
    assign w_grant_i = i_read && (!w_d_req || (r_starve == SW'(STARVE_LIMIT)));
    assign w_in_wait = (r_state == WAIT);
    assign w_finish  = w_in_wait && (mem_ready || w_expired);

    arb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .enable  (w_in_wait),
        .clear   (!w_in_wait),
        .expired (w_expired)
    );

    assign mem_oe    = w_in_wait && !r_write;
    assign mem_we    = w_in_wait && r_write;
    assign mem_addr  = w_in_wait ? r_addr  : '0;
    assign mem_wdata = w_in_wait ? r_wdata : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_state_next = WAIT;
            WAIT:    if (w_finish)  w_state_next = RELEASE;
            RELEASE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_owner  <= OWN_D;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_starve <= '0;
            d_rdata  <= '0;
            d_ready  <= 1'b0;
            i_rdata  <= '0;
            i_ready  <= 1'b0;
            err      <= 1'b0;
        end else begin
            d_ready <= 1'b0;
            i_ready <= 1'b0;
            if ((r_state == IDLE) && w_any_req) begin
                r_owner <= w_grant_i ? OWN_I : OWN_D;
                r_write <= !w_grant_i && d_write;
                r_addr  <= w_grant_i ? i_addr : d_addr;
                r_wdata <= w_grant_i ? '0 : d_wdata;
                if (w_grant_i || !i_read) begin
                    r_starve <= '0;
                end else if (r_starve != SW'(STARVE_LIMIT)) begin
                    r_starve <= r_starve + 1'b1;
                end
            end
            // A real completion takes precedence over a same-cycle timeout
            if (w_finish) begin
                if (r_owner == OWN_I) begin
                    i_ready <= 1'b1;
                    i_rdata <= mem_ready ? mem_rdata : '0;
                end else begin
                    d_ready <= 1'b1;
                    if (!mem_ready) begin
                        d_rdata <= '0;
                    end else if (!r_write) begin
                        d_rdata <= mem_rdata;
                    end
                end
                if (!mem_ready) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire
